// File: rtl/board_cursor_pkg.sv
// Shared types, width helpers and default timing for the board cursor controller.
package board_cursor_pkg;

  // Button index used by the conditioner array and the move logic.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam int NUM_DIRS = 4;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/board_cursor_if.sv
// Button inputs and cursor outputs of board_cursor; master is the UI side, slave is the cursor.
interface board_cursor_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  import board_cursor_pkg::*;

  localparam int ROW_W = idx_width(ROWS);
  localparam int COL_W = idx_width(COLS);

  logic             btn_up;
  logic             btn_down;
  logic             btn_left;
  logic             btn_right;
  logic             enable;
  logic             home;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             moved;
  logic             wrapped;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, enable, home,
    input  row, col, moved, wrapped
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, enable, home,
    output row, col, moved, wrapped
  );

endinterface

// File: rtl/board_cursor_button_conditioner.sv
// One push-button: synchroniser, debounce, rising-edge step pulse and, when
// BOARD_CURSOR_AUTOREPEAT_EN is defined, a hold-to-repeat step generator.
module button_conditioner
  import board_cursor_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic step
);

  localparam int              DB_W    = idx_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  logic                   level_prev_q, level_prev_d;
  logic                   btn_sync;
  logic                   press;

  assign btn_sync = sync_q[SYNC_STAGES-1];
  assign press    = level_q & ~level_prev_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], btn_raw};
    level_d      = level_q;
    level_prev_d = level_q;
    db_cnt_d     = '0;
    // The counter only advances on disagreeing samples; any agreeing sample restarts it.
    if (btn_sync != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q       <= '0;
      db_cnt_q     <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      db_cnt_q     <= db_cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
    end
  end

`ifdef BOARD_CURSOR_AUTOREPEAT_EN
  localparam int               RPT_W     = idx_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rpt_fire;

  // Down-counter: loaded on the press step, fires at zero while the level stays high.
  always_comb begin
    rpt_d    = '0;
    rpt_fire = 1'b0;
    if (press) begin
      rpt_d = RPT_FIRST;
    end else if (level_q) begin
      if (rpt_q == '0) begin
        rpt_fire = 1'b1;
        rpt_d    = RPT_NEXT;
      end else begin
        rpt_d = rpt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end

  assign step = press | rpt_fire;
`else
  logic unused_repeat;
  assign unused_repeat = (REPEAT_DELAY > REPEAT_PERIOD);
  assign step          = press;
`endif

endmodule

// File: rtl/board_cursor.sv
// 2-D cursor controller: four conditioned buttons step a registered row/column
// position with wrap or saturate at the board edges.
module board_cursor
  import board_cursor_pkg::*;
#(
  parameter int ROWS            = 8,
  parameter int COLS            = 8,
  parameter int WRAP            = 1,
  parameter int HOME_ROW        = 0,
  parameter int HOME_COL        = 0,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic           clk,
  input  logic           reset,
  board_cursor_if.slave  bus
);

  localparam int               ROW_W    = idx_width(ROWS);
  localparam int               COL_W    = idx_width(COLS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_HOME = ROW_W'(HOME_ROW);
  localparam logic [COL_W-1:0] COL_HOME = COL_W'(HOME_COL);

  logic [NUM_DIRS-1:0] btn_raw;
  logic [NUM_DIRS-1:0] step;
  logic [NUM_DIRS-1:0] step_en;

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             moved_q, moved_d;
  logic             wrapped_q, wrapped_d;
  logic             row_wrap, col_wrap;

  assign btn_raw[DIR_UP]    = bus.btn_up;
  assign btn_raw[DIR_DOWN]  = bus.btn_down;
  assign btn_raw[DIR_LEFT]  = bus.btn_left;
  assign btn_raw[DIR_RIGHT] = bus.btn_right;

  for (genvar i = 0; i < NUM_DIRS; i++) begin : g_cond
    button_conditioner #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_cond (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_raw[i]),
      .step   (step[i])
    );
  end

  // Conditioners keep running while disabled; only their steps are discarded here.
  assign step_en = bus.enable ? step : '0;

  always_comb begin
    row_d    = row_q;
    col_d    = col_q;
    row_wrap = 1'b0;
    col_wrap = 1'b0;
    if (bus.home) begin
      row_d = ROW_HOME;
      col_d = COL_HOME;
    end else begin
      // Opposing steps on one axis cancel; the two axes are independent.
      if (step_en[DIR_UP] && !step_en[DIR_DOWN]) begin
        if (row_q != '0) begin
          row_d = row_q - 1'b1;
        end else if (WRAP != 0) begin
          row_d    = ROW_LAST;
          row_wrap = 1'b1;
        end
      end else if (step_en[DIR_DOWN] && !step_en[DIR_UP]) begin
        if (row_q != ROW_LAST) begin
          row_d = row_q + 1'b1;
        end else if (WRAP != 0) begin
          row_d    = '0;
          row_wrap = 1'b1;
        end
      end

      if (step_en[DIR_LEFT] && !step_en[DIR_RIGHT]) begin
        if (col_q != '0) begin
          col_d = col_q - 1'b1;
        end else if (WRAP != 0) begin
          col_d    = COL_LAST;
          col_wrap = 1'b1;
        end
      end else if (step_en[DIR_RIGHT] && !step_en[DIR_LEFT]) begin
        if (col_q != COL_LAST) begin
          col_d = col_q + 1'b1;
        end else if (WRAP != 0) begin
          col_d    = '0;
          col_wrap = 1'b1;
        end
      end
    end
    moved_d   = (row_d != row_q) || (col_d != col_q);
    wrapped_d = row_wrap | col_wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q     <= ROW_HOME;
      col_q     <= COL_HOME;
      moved_q   <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      moved_q   <= moved_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign bus.row     = row_q;
  assign bus.col     = col_q;
  assign bus.moved   = moved_q;
  assign bus.wrapped = wrapped_q;

endmodule

// File: tb/tb_board_cursor.sv
// Bench for board_cursor: a wrapping and a saturating instance share one stimulus;
// expected outputs are queued per cycle and compared at every falling edge.
module tb_board_cursor;

  localparam int TB_ROWS   = 8;
  localparam int TB_COLS   = 8;
  localparam int TB_SYNC   = 2;
  localparam int TB_DEB    = 4;
  localparam int TB_RDELAY = 10;
  localparam int TB_RPER   = 3;
  localparam int LAT       = TB_SYNC + TB_DEB + 1;  // drive at falling edge -> visible update

  typedef struct {
    int cyc;
    int rw; int cw; bit mw; bit ww;
    int rs; int cs; bit ms; bit ws;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset;
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  string phase = "init";
  exp_t  q[$];
  exp_t  cur;
  exp_t  pred;

  board_cursor_if #(.ROWS(TB_ROWS), .COLS(TB_COLS)) bus_w ();
  board_cursor_if #(.ROWS(TB_ROWS), .COLS(TB_COLS)) bus_s ();

  assign bus_s.btn_up    = bus_w.btn_up;
  assign bus_s.btn_down  = bus_w.btn_down;
  assign bus_s.btn_left  = bus_w.btn_left;
  assign bus_s.btn_right = bus_w.btn_right;
  assign bus_s.enable    = bus_w.enable;
  assign bus_s.home      = bus_w.home;

  board_cursor #(
    .ROWS(TB_ROWS), .COLS(TB_COLS), .WRAP(1), .HOME_ROW(0), .HOME_COL(0),
    .SYNC_STAGES(TB_SYNC), .DEBOUNCE_CYCLES(TB_DEB),
    .REPEAT_DELAY(TB_RDELAY), .REPEAT_PERIOD(TB_RPER)
  ) dut_w (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_w)
  );

  board_cursor #(
    .ROWS(TB_ROWS), .COLS(TB_COLS), .WRAP(0), .HOME_ROW(0), .HOME_COL(0),
    .SYNC_STAGES(TB_SYNC), .DEBOUNCE_CYCLES(TB_DEB),
    .REPEAT_DELAY(TB_RDELAY), .REPEAT_PERIOD(TB_RPER)
  ) dut_s (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One axis of the reference model.
  function automatic void axis(input int p, input bit dec, input bit inc, input int n,
                               input bit wrap, output int np, output bit wr);
    np = p;
    wr = 1'b0;
    if (dec && !inc) begin
      if (p > 0) np = p - 1;
      else if (wrap) begin np = n - 1; wr = 1'b1; end
    end else if (inc && !dec) begin
      if (p < n - 1) np = p + 1;
      else if (wrap) begin np = 0; wr = 1'b1; end
    end
  endfunction

  task automatic compare(input exp_t e);
    logic [15:0] obs;
    logic [15:0] req;
    obs = {bus_w.row, bus_w.col, bus_w.moved, bus_w.wrapped,
           bus_s.row, bus_s.col, bus_s.moved, bus_s.wrapped};
    req = {3'(e.rw), 3'(e.cw), e.mw, e.ww, 3'(e.rs), 3'(e.cs), e.ms, e.ws};
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed w(r%0d c%0d m%0b w%0b) s(r%0d c%0d m%0b w%0b) expected w(r%0d c%0d m%0b w%0b) s(r%0d c%0d m%0b w%0b)",
             phase, cyc, obs[15:13], obs[12:10], obs[9], obs[8], obs[7:5], obs[4:2], obs[1], obs[0],
             e.rw, e.cw, e.mw, e.ww, e.rs, e.cs, e.ms, e.ws);
    end
  endtask

  task automatic check_now();
    exp_t e;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e   = q.pop_front();
      cur = e;
    end else begin
      e    = cur;
      e.mw = 1'b0; e.ww = 1'b0; e.ms = 1'b0; e.ws = 1'b0;
    end
    compare(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      check_now();
    end
  endtask

  task automatic push_step(input int at, input bit u, input bit d, input bit l, input bit r);
    exp_t e;
    bit   wr_r, wr_c;
    e.cyc = at;
    axis(pred.rw, u, d, TB_ROWS, 1'b1, e.rw, wr_r);
    axis(pred.cw, l, r, TB_COLS, 1'b1, e.cw, wr_c);
    e.mw = (e.rw != pred.rw) || (e.cw != pred.cw);
    e.ww = wr_r | wr_c;
    axis(pred.rs, u, d, TB_ROWS, 1'b0, e.rs, wr_r);
    axis(pred.cs, l, r, TB_COLS, 1'b0, e.cs, wr_c);
    e.ms = (e.rs != pred.rs) || (e.cs != pred.cs);
    e.ws = wr_r | wr_c;
    q.push_back(e);
    pred = e;
  endtask

  task automatic push_home(input int at);
    exp_t e;
    e.cyc = at;
    e.rw = 0; e.cw = 0; e.rs = 0; e.cs = 0;
    e.mw = (pred.rw != 0) || (pred.cw != 0);
    e.ms = (pred.rs != 0) || (pred.cs != 0);
    e.ww = 1'b0; e.ws = 1'b0;
    q.push_back(e);
    pred = e;
  endtask

  task automatic set_btn(input bit u, input bit d, input bit l, input bit r);
    bus_w.btn_up    = u;
    bus_w.btn_down  = d;
    bus_w.btn_left  = l;
    bus_w.btn_right = r;
  endtask

  // Clean press held for 6 samples, then released long enough to debounce low.
  task automatic press(input bit u, input bit d, input bit l, input bit r);
    set_btn(u, d, l, r);
    push_step(cyc + LAT, u, d, l, r);
    cycles(6);
    set_btn(0, 0, 0, 0);
    cycles(10);
  endtask

  initial begin
    int n_steps;
    int base;
    exp_t home_e;

    home_e = '{default: 0};
    cur    = home_e;
    pred   = home_e;
    reset  = 1'b1;
    set_btn(0, 0, 0, 0);
    bus_w.enable = 1'b1;
    bus_w.home   = 1'b0;

    phase = "reset";
    cycles(3);
    reset = 1'b0;
    cycles(3);

    phase = "up_wrap";
    press(1, 0, 0, 0);

    phase = "right_bounce";
    repeat (5) begin
      set_btn(0, 0, 0, 1);
      cycles(3);
      set_btn(0, 0, 0, 0);
      cycles(3);
    end
    cycles(10);

    phase = "left_edge";
    press(0, 0, 1, 0);

    phase = "down_edge";
    press(0, 1, 0, 0);

    phase = "cancel_diag";
    press(1, 1, 0, 1);

    phase = "repeat_down";
`ifdef BOARD_CURSOR_AUTOREPEAT_EN
    n_steps = 8;
`else
    n_steps = 1;
`endif
    set_btn(0, 1, 0, 0);
    base = cyc + LAT;
    for (int k = 0; k < n_steps; k++) begin
      push_step((k == 0) ? base : base + TB_RDELAY + TB_RPER * (k - 1), 0, 1, 0, 0);
    end
    cycles(30);
    set_btn(0, 0, 0, 0);
    cycles(15);

    phase = "enable_low";
    bus_w.enable = 1'b0;
    set_btn(0, 0, 0, 1);
    cycles(6);
    set_btn(0, 0, 0, 0);
    cycles(10);
    bus_w.enable = 1'b1;
    cycles(5);

    phase = "home_on_step";
    set_btn(0, 0, 0, 1);
    push_home(cyc + LAT);
    cycles(6);
    bus_w.home = 1'b1;
    cycles(1);
    bus_w.home = 1'b0;
    set_btn(0, 0, 0, 0);
    cycles(10);

    phase = "home_idle";
    bus_w.home = 1'b1;
    push_home(cyc + 1);
    cycles(1);
    bus_w.home = 1'b0;
    cycles(2);

    phase = "right_step";
    press(0, 0, 0, 1);

    phase = "reset_mid_debounce";
    set_btn(1, 0, 0, 0);
    cycles(3);
    reset = 1'b1;
    #1;
    cur  = home_e;
    pred = home_e;
    compare(home_e);
    cycles(2);
    reset = 1'b0;
    phase = "held_through_reset";
    push_step(cyc + LAT, 1, 0, 0, 0);
    cycles(5);
    set_btn(0, 0, 0, 0);
    cycles(12);

    phase = "queue_drained";
    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL %s pending=%0d expected=0", phase, q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
